// File: rtl/dbus_arbiter_pkg.sv
// Shared types and constants for the data-bus arbiter slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dbus_arb_pkg;

    // Arbiter ownership state; grant is taken directly from this register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Master index used for the round-robin priority pointer.
    typedef logic mst_idx_t;

    localparam mst_idx_t M0 = 1'b0;
    localparam mst_idx_t M1 = 1'b1;

    // Width of the per-access watchdog counter (TIMEOUT is limited to 255).
    localparam int unsigned WD_CW = 8;

    // The master that gets priority after the given one releases the bus.
    function automatic mst_idx_t other_mst(input mst_idx_t m);
        return ~m;
    endfunction

endpackage

// File: rtl/dbus_arbiter_wb_watchdog.sv
// Per-access watchdog: counts cycles of an outstanding strobe with no ack.
// Latency: expire_o is combinational in the cycle the count reaches TIMEOUT-1.
// Backpressure: none; it only observes the strobe/ack handshake.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CW      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,     // strobe outstanding and no ack this cycle
    input  logic clr_i,     // ownership boundary, restart from zero
    output logic expire_o
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // An ack arriving in the limit cycle drops run_i, so ack wins over expiry.
    assign expire_o = run_i & ~clr_i & (cnt_q == LIMIT);

    // Next count: increment while waiting, restart on any break in the wait or on expiry.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || !run_i || expire_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master Wishbone classic arbiter with round-robin grant, cycle locking and access watchdog.
// Latency: one cycle from cyc in IDLE to the slave seeing the master; data/ack paths are combinational.
// Backpressure: the non-granted master sees no ack and stalls by holding stb; a hung slave turns into ERR.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int unsigned AW      = 13,
    parameter int unsigned DW      = 16,
    parameter int unsigned SW      = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [SW-1:0] m0_sel,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_w,
    output logic [DW-1:0] m0_dat_r,
    output logic          m0_ack,
    output logic          m0_err,

    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [SW-1:0] m1_sel,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_w,
    output logic [DW-1:0] m1_dat_r,
    output logic          m1_ack,
    output logic          m1_err,

    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [SW-1:0] s_sel,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_w,
    input  logic [DW-1:0] s_dat_r,
    input  logic          s_ack
);

    arb_state_t state_q;
    mst_idx_t   prio_q;
    logic       err_pend_q;

    logic gnt0;
    logic gnt1;
    logic wd_run;
    logic wd_clr;
    logic wd_expire;

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    // Only a strobe actually presented to the slave is timed; IDLE marks an ownership boundary.
    assign wd_run = s_stb & ~s_ack;
    assign wd_clr = (state_q == IDLE);

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CW      (WD_CW)
    ) u_wd (
        .clk      (clk),
        .rst_n    (reset),
        .run_i    (wd_run),
        .clr_i    (wd_clr),
        .expire_o (wd_expire)
    );

    // Grant FSM: owner is held while its cyc stays high, and every hand-over passes through IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            prio_q     <= M0;
            err_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    err_pend_q <= 1'b0;
                    if (m0_cyc && m1_cyc) begin
                        state_q <= (prio_q == M0) ? GNT0 : GNT1;
                    end else if (m0_cyc) begin
                        state_q <= GNT0;
                    end else if (m1_cyc) begin
                        state_q <= GNT1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc) begin
                        state_q    <= IDLE;
                        prio_q     <= other_mst(M0);
                        err_pend_q <= 1'b0;
                    end else if (wd_expire) begin
                        err_pend_q <= 1'b1;
                    end
                end
                GNT1: begin
                    if (!m1_cyc) begin
                        state_q    <= IDLE;
                        prio_q     <= other_mst(M1);
                        err_pend_q <= 1'b0;
                    end else if (wd_expire) begin
                        err_pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    err_pend_q <= 1'b0;
                end
            endcase
        end
    end

    // Slave-side mux from the registered grant; stb needs cyc and is masked after a timeout.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        if (gnt0) begin
            s_cyc   = m0_cyc;
            s_stb   = m0_cyc & m0_stb & ~err_pend_q;
            s_we    = m0_we;
            s_sel   = m0_sel;
            s_adr   = m0_adr;
            s_dat_w = m0_dat_w;
        end else if (gnt1) begin
            s_cyc   = m1_cyc;
            s_stb   = m1_cyc & m1_stb & ~err_pend_q;
            s_we    = m1_we;
            s_sel   = m1_sel;
            s_adr   = m1_adr;
            s_dat_w = m1_dat_w;
        end
    end

    // Return path: only the owner sees data/ack/err; a late ack after a timeout is swallowed.
    always_comb begin
        m0_dat_r = gnt0 ? s_dat_r : '0;
        m1_dat_r = gnt1 ? s_dat_r : '0;
        m0_ack   = gnt0 & s_ack & ~err_pend_q;
        m1_ack   = gnt1 & s_ack & ~err_pend_q;
        m0_err   = gnt0 & wd_expire;
        m1_err   = gnt1 & wd_expire;
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter; the bench plays both masters and the slave.
// Latency: checks are taken 1-2 ns after the rising edge, after inputs settle.
// Backpressure: slave ack is driven explicitly per vector.
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_cyc, m0_stb, m0_we;
    logic [1:0]  m0_sel;
    logic [12:0] m0_adr;
    logic [15:0] m0_dat_w, m0_dat_r;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [1:0]  m1_sel;
    logic [12:0] m1_adr;
    logic [15:0] m1_dat_w, m1_dat_r;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [1:0]  s_sel;
    logic [12:0] s_adr;
    logic [15:0] s_dat_w;
    logic [15:0] s_dat_r;
    logic        s_ack;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(
        .AW(13), .DW(16), .SW(2), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 2'b11; m0_adr = 13'h100; m0_dat_w = 16'h0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 2'b11; m1_adr = 13'h200; m1_dat_w = 16'h0;
        s_ack = 0; s_dat_r = 16'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state, with a stray slave ack present while in reset.
        idle_inputs();
        reset = 0;
        s_ack = 1;
        #12;
        chk("rst_s_cyc", 32'(s_cyc), 0);
        chk("rst_s_stb", 32'(s_stb), 0);
        chk("rst_s_adr", 32'(s_adr), 0);
        chk("rst_s_dat_w", 32'(s_dat_w), 0);
        chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 0);

        // Single master read: one-cycle grant latency, ack two cycles later.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 13'h0010;
        #1;
        chk("rd_latency_stb", 32'(s_stb), 0);
        tick();
        chk("rd_s_stb", 32'(s_stb), 1);
        chk("rd_s_adr", 32'(s_adr), 32'h10);
        tick();
        chk("rd_noack", 32'(m0_ack), 0);
        tick();
        s_ack = 1; s_dat_r = 16'hBEEF;
        #1;
        chk("rd_ack", 32'(m0_ack), 1);
        chk("rd_dat", 32'(m0_dat_r), 32'hBEEF);
        chk("rd_m1_ack", 32'(m1_ack), 0);
        chk("rd_m1_dat", 32'(m1_dat_r), 0);
        tick();
        idle_inputs();
        tick();

        // Contention straight after reset: m0 first, one IDLE cycle, then m1; then back to m0.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("ct_gnt0_adr", 32'(s_adr), 32'h100);
        tick();
        m0_cyc = 0; m0_stb = 0;
        #1;
        chk("ct_drop_cyc", 32'(s_cyc), 0);
        tick();
        chk("ct_idle_gap", 32'(s_cyc), 0);
        tick();
        chk("ct_gnt1_adr", 32'(s_adr), 32'h200);
        chk("ct_gnt1_cyc", 32'(s_cyc), 1);
        m0_cyc = 1; m0_stb = 1;
        tick();
        m1_cyc = 0; m1_stb = 0;
        tick();
        chk("ct_idle_gap2", 32'(s_cyc), 0);
        tick();
        chk("ct_back_gnt0", 32'(s_adr), 32'h100);
        tick();
        idle_inputs();
        tick();

        // Round-robin: after an m0-only cycle, simultaneous requests go to m1 first.
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        tick();
        tick();
        m0_cyc = 0; m0_stb = 0;
        tick();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("rr_gnt1_first", 32'(s_adr), 32'h200);
        idle_inputs();
        tick();
        tick();

        // Lock: four contiguous m0 beats; m1 requests during beat 1 and waits.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 13'h20;
        tick();
        for (int i = 0; i < 4; i++) begin
            m0_adr = 13'(32'h20 + i);
            s_ack = 1; s_dat_r = 16'(i);
            if (i == 1) begin
                m1_cyc = 1; m1_stb = 1;
            end
            #1;
            chk("lk_beat_adr", 32'(s_adr), 32'h20 + i);
            chk("lk_m0_ack", 32'(m0_ack), 1);
            chk("lk_m1_ack", 32'(m1_ack), 0);
            tick();
        end
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        #1;
        chk("lk_release", 32'(s_cyc), 0);
        tick();
        chk("lk_idle_gap", 32'(s_cyc), 0);
        tick();
        chk("lk_gnt1_adr", 32'(s_adr), 32'h200);
        idle_inputs();
        tick();
        tick();

        // Timeout: slave never acks an m1 write; err in stb cycle 15, stb masked after.
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_dat_w = 16'hA5A5;
        tick();
        for (int c = 1; c < 15; c++) begin
            chk("wd_quiet", 32'(m1_err), 0);
            tick();
        end
        chk("wd_err", 32'(m1_err), 1);
        chk("wd_err_stb", 32'(s_stb), 1);
        chk("wd_m0_err", 32'(m0_err), 0);
        tick();
        chk("wd_stb_masked", 32'(s_stb), 0);
        chk("wd_err_pulse", 32'(m1_err), 0);
        chk("wd_cyc_held", 32'(s_cyc), 1);
        s_ack = 1;
        #1;
        chk("wd_late_ack", 32'(m1_ack), 0);
        tick();
        idle_inputs();
        tick();
        tick();

        // Ack in the timeout cycle wins over the error.
        do_reset();
        m1_cyc = 1; m1_stb = 1;
        tick();
        repeat (14) tick();
        s_ack = 1;
        #1;
        chk("wd_ack_wins_ack", 32'(m1_ack), 1);
        chk("wd_ack_wins_err", 32'(m1_err), 0);
        tick();
        idle_inputs();
        tick();

        // Reset mid-access with prio at M1; outputs clear at once and prio returns to M0.
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        tick();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("rm_drop_idle", 32'(s_cyc), 0);
        tick();
        s_ack = 1;
        #1;
        chk("rm_gnt1_ack", 32'(m1_ack), 1);
        reset = 0;
        #1;
        chk("rm_s_ctrl", 32'({s_cyc, s_stb, s_we}), 0);
        chk("rm_s_adr", 32'(s_adr), 0);
        chk("rm_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 0);
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 1;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("rm_prio_m0", 32'(s_adr), 32'h100);
        idle_inputs();
        tick();
        tick();

        // Byte write from m0; m1 return data stays zero.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 2'b10; m0_dat_w = 16'h12AB;
        m1_dat_w = 16'h5555; s_dat_r = 16'h7777;
        tick();
        chk("bw_sel", 32'(s_sel), 32'h2);
        chk("bw_dat_w", 32'(s_dat_w), 32'h12AB);
        chk("bw_we", 32'(s_we), 1);
        chk("bw_m1_dat_r", 32'(m1_dat_r), 0);
        chk("bw_m0_dat_r", 32'(m0_dat_r), 32'h7777);
        idle_inputs();
        tick();
        tick();

        // Strobe without cyc never reaches the slave.
        do_reset();
        m0_stb = 1; s_ack = 1;
        tick();
        tick();
        chk("nocyc_stb", 32'(s_stb), 0);
        chk("nocyc_cyc", 32'(s_cyc), 0);
        chk("nocyc_ack", 32'(m0_ack), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
